// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage holding the EX/MEM register, data RAM and branch resolution,
// plus an FSM that streams the whole RAM out after the program halts.
module mem_stage #(
  parameter int ADDR_BITS = 9,
  parameter int MEM_DEPTH = 512
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 RegWriteE,
  input  logic                 MemtoRegE,
  input  logic                 MemWriteE,
  input  logic                 BranchE,
  input  logic                 JumpE,
  input  logic [5:0]           ALUopE,
  input  logic [31:0]          WriteData_in,
  input  logic [31:0]          PCBranch_in,
  input  logic [4:0]           wb_addr_in,
  input  logic [31:0]          ALUOut_in,
  input  logic                 dump_req,
  output logic                 RegWriteM,
  output logic                 MemtoRegM,
  output logic                 JumpM,
  output logic [5:0]           ALUopM,
  output logic [4:0]           wb_addr_out,
  output logic [31:0]          ALUOutM,
  output logic [31:0]          ReadDataM,
  output logic [31:0]          PCBranchM,
  output logic                 PCSrcM,
  output logic                 dump_valid,
  output logic [ADDR_BITS-1:0] dump_addr,
  output logic [31:0]          dump_data,
  output logic                 dump_done
);
  typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;
  localparam logic [ADDR_BITS:0] LAST = (ADDR_BITS+1)'(MEM_DEPTH - 1);
  logic                 regwrite_q, memtoreg_q, memwrite_q, branch_q, jump_q;
  logic [5:0]           aluop_q;
  logic [4:0]           wb_addr_q;
  logic [31:0]          alu_q, wdata_q, pcbranch_q;
  state_t               state_q;
  logic [ADDR_BITS:0]   cnt_q;
  logic                 valid_q, done_q;
  logic [31:0]          mem [MEM_DEPTH];
  logic [ADDR_BITS-1:0] idx;
  logic                 zero;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memwrite_q <= 1'b0;
      branch_q   <= 1'b0;
      jump_q     <= 1'b0;
      aluop_q    <= '0;
      wb_addr_q  <= '0;
      alu_q      <= '0;
      wdata_q    <= '0;
      pcbranch_q <= '0;
    end else begin
      regwrite_q <= RegWriteE;
      memtoreg_q <= MemtoRegE;
      memwrite_q <= MemWriteE;
      branch_q   <= BranchE;
      jump_q     <= JumpE;
      aluop_q    <= ALUopE;
      wb_addr_q  <= wb_addr_in;
      alu_q      <= ALUOut_in;
      wdata_q    <= WriteData_in;
      pcbranch_q <= PCBranch_in;
    end
  end
  // Byte address to word index; low bits and bits above the RAM size are dropped.
  assign idx = alu_q[ADDR_BITS+1:2];
  always_ff @(posedge CLK) begin
    if (memwrite_q) mem[idx] <= wdata_q;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (dump_req) begin
          state_q <= DUMP;
          cnt_q   <= '0;
          valid_q <= 1'b1;
        end
        DUMP: if (cnt_q == LAST) begin
          state_q <= DONE;
          valid_q <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end
  assign zero        = (alu_q == 32'd0);
  assign PCSrcM      = branch_q & (aluop_q == 6'h04 ? zero : aluop_q == 6'h05 ? ~zero : 1'b0);
  assign RegWriteM   = regwrite_q;
  assign MemtoRegM   = memtoreg_q;
  assign JumpM       = jump_q;
  assign ALUopM      = aluop_q;
  assign wb_addr_out = wb_addr_q;
  assign ALUOutM     = alu_q;
  assign PCBranchM   = pcbranch_q;
  assign ReadDataM   = mem[idx];
  assign dump_valid  = valid_q;
  assign dump_addr   = cnt_q[ADDR_BITS-1:0];
  assign dump_data   = mem[dump_addr];
  assign dump_done   = done_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: vector table, hand sequences and a random run against an array-based RAM model.
module tb_mem_stage;
  typedef struct packed {
    logic        rw, m2r, mw, br, j;
    logic [5:0]  op;
    logic [4:0]  wba;
    logic [31:0] wd, pcb, alu;
  } e_t;
  typedef struct {
    string       name;
    logic        mw, br;
    logic [5:0]  op;
    logic [31:0] alu, wd, rd;
    logic        pc;
  } vec_t;
  logic        CLK = 1'b0, RESET = 1'b0, dump_req = 1'b0;
  e_t          e = '0, prev = '0;
  logic        RegWriteM, MemtoRegM, JumpM, PCSrcM, dump_valid, dump_done;
  logic [5:0]  ALUopM;
  logic [4:0]  wb_addr_out;
  logic [31:0] ALUOutM, ReadDataM, PCBranchM, dump_data;
  logic [8:0]  dump_addr;
  logic [31:0] mem_m [512];
  vec_t        v [9];
  int          errors = 0, checks = 0, n;

  always #5 CLK = ~CLK;

  mem_stage dut (
    .CLK(CLK), .RESET(RESET),
    .RegWriteE(e.rw), .MemtoRegE(e.m2r), .MemWriteE(e.mw), .BranchE(e.br), .JumpE(e.j),
    .ALUopE(e.op), .WriteData_in(e.wd), .PCBranch_in(e.pcb), .wb_addr_in(e.wba),
    .ALUOut_in(e.alu), .dump_req(dump_req),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .JumpM(JumpM), .ALUopM(ALUopM),
    .wb_addr_out(wb_addr_out), .ALUOutM(ALUOutM), .ReadDataM(ReadDataM),
    .PCBranchM(PCBranchM), .PCSrcM(PCSrcM),
    .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data), .dump_done(dump_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: a store issued in EX lands in RAM one edge after it reaches MEM.
  task automatic tick();
    @(posedge CLK);
    if (prev.mw) mem_m[prev.alu[10:2]] = prev.wd;
    prev = RESET ? '0 : e;
    #1;
  endtask

  function automatic logic taken(input e_t b);
    if (!b.br) return 1'b0;
    if (b.op == 6'h04) return b.alu == 0;
    if (b.op == 6'h05) return b.alu != 0;
    return 1'b0;
  endfunction

  function automatic e_t rand_e();
    e_t r;
    r.rw  = 1'($urandom);
    r.m2r = 1'($urandom);
    r.mw  = 1'($urandom);
    r.br  = 1'($urandom);
    r.j   = 1'($urandom);
    r.wba = 5'($urandom);
    r.wd  = $urandom;
    r.pcb = $urandom;
    r.op  = ($urandom_range(0, 2) == 0) ? 6'h04 : ($urandom_range(0, 1) == 0) ? 6'h05 : 6'($urandom);
    r.alu = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    return r;
  endfunction

  task automatic check_model();
    chk("RegWriteM", 32'(RegWriteM), 32'(prev.rw));
    chk("MemtoRegM", 32'(MemtoRegM), 32'(prev.m2r));
    chk("JumpM", 32'(JumpM), 32'(prev.j));
    chk("ALUopM", 32'(ALUopM), 32'(prev.op));
    chk("wb_addr_out", 32'(wb_addr_out), 32'(prev.wba));
    chk("ALUOutM", ALUOutM, prev.alu);
    chk("PCBranchM", PCBranchM, prev.pcb);
    chk("ReadDataM", ReadDataM, mem_m[prev.alu[10:2]]);
    chk("PCSrcM", 32'(PCSrcM), 32'(taken(prev)));
  endtask

  initial begin
    v[0] = '{"lw_0x10",  1'b0, 1'b0, 6'h23, 32'h10,  32'h0, 32'hDEADBEEF, 1'b0};
    v[1] = '{"lw_0x13",  1'b0, 1'b0, 6'h23, 32'h13,  32'h0, 32'hDEADBEEF, 1'b0};
    v[2] = '{"lw_wrap",  1'b0, 1'b0, 6'h23, 32'h810, 32'h0, 32'hDEADBEEF, 1'b0};
    v[3] = '{"beq_zero", 1'b0, 1'b1, 6'h04, 32'h0,   32'h0, 32'h0,        1'b1};
    v[4] = '{"beq_nz",   1'b0, 1'b1, 6'h04, 32'h7,   32'h0, 32'h3,        1'b0};
    v[5] = '{"bne_nz",   1'b0, 1'b1, 6'h05, 32'h7,   32'h0, 32'h3,        1'b1};
    v[6] = '{"bne_zero", 1'b0, 1'b1, 6'h05, 32'h0,   32'h0, 32'h0,        1'b0};
    v[7] = '{"nobranch", 1'b0, 1'b0, 6'h04, 32'h0,   32'h0, 32'h0,        1'b0};
    v[8] = '{"br_otherop", 1'b0, 1'b1, 6'h23, 32'h0, 32'h0, 32'h0,        1'b0};
    foreach (mem_m[i]) mem_m[i] = '0;

    RESET = 1'b1;
    repeat (2) begin
      e = rand_e();
      dump_req = 1'($urandom);
      tick();
    end
    chk("rst_RegWriteM", 32'(RegWriteM), 0);
    chk("rst_MemtoRegM", 32'(MemtoRegM), 0);
    chk("rst_JumpM", 32'(JumpM), 0);
    chk("rst_ALUopM", 32'(ALUopM), 0);
    chk("rst_wb_addr", 32'(wb_addr_out), 0);
    chk("rst_ALUOutM", ALUOutM, 0);
    chk("rst_PCBranchM", PCBranchM, 0);
    chk("rst_PCSrcM", 32'(PCSrcM), 0);
    chk("rst_dump_valid", 32'(dump_valid), 0);
    chk("rst_dump_done", 32'(dump_done), 0);
    RESET = 1'b0;
    dump_req = 1'b0;

    for (int i = 0; i < 512; i++) begin
      e = '0;
      e.mw = 1'b1;
      e.alu = 32'(i * 4);
      e.wd = 32'(i * 3);
      tick();
    end
    e = '0;
    tick();

    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    n = 0;
    while (dump_valid && n < 600) begin
      chk("dump_addr", 32'(dump_addr), 32'(n));
      chk("dump_data", dump_data, 32'(n * 3));
      n++;
      tick();
    end
    chk("dump_len", 32'(n), 512);
    chk("dump_done_set", 32'(dump_done), 1);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    repeat (3) tick();
    chk("done_ignore_valid", 32'(dump_valid), 0);
    chk("done_sticky", 32'(dump_done), 1);

    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    n = 0;
    while (dump_addr != 9'd100 && n < 200) begin
      n++;
      tick();
    end
    chk("mid_reach_100", 32'(dump_addr), 100);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("abort_valid", 32'(dump_valid), 0);
    chk("abort_done", 32'(dump_done), 0);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    chk("restart_valid", 32'(dump_valid), 1);
    chk("restart_addr0", 32'(dump_addr), 0);
    tick();
    chk("restart_addr1", 32'(dump_addr), 1);
    chk("restart_data1", dump_data, 3);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;

    e = '0;
    e.mw = 1'b1;
    e.alu = 32'h10;
    e.wd = 32'hDEADBEEF;
    tick();
    foreach (v[i]) begin
      e = '0;
      e.mw = v[i].mw;
      e.br = v[i].br;
      e.op = v[i].op;
      e.alu = v[i].alu;
      e.wd = v[i].wd;
      tick();
      chk({v[i].name, "_rd"}, ReadDataM, v[i].rd);
      chk({v[i].name, "_pc"}, 32'(PCSrcM), 32'(v[i].pc));
    end

    e = '0;
    e.mw = 1'b1;
    e.alu = 32'h14;
    e.wd = 32'h1;
    tick();
    e.wd = 32'h2;
    tick();
    chk("rdw_old", ReadDataM, 32'h1);
    e.mw = 1'b0;
    tick();
    chk("rdw_new", ReadDataM, 32'h2);

    repeat (400) begin
      e = rand_e();
      tick();
      check_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
